// File: rtl/pcie_txn_pkg.sv
// Shared PCIe transaction definitions: default sizing, the tag type and
// the state of the timeout report register.
package pcie_txn_pkg;

    localparam int DEF_TIMER_WIDTH = 44;
    localparam int DEF_TAG_COUNT   = 32;
    localparam int DEF_TAG_WIDTH   = $clog2(DEF_TAG_COUNT);

    typedef logic [DEF_TAG_WIDTH-1:0] tag_t;

    typedef enum logic {
        TO_IDLE    = 1'b0,
        TO_PENDING = 1'b1
    } to_state_e;

endpackage

// File: rtl/cpl_tag_table.sv
// Per-tag valid bit and issue stamp, with separate write ports for request
// allocation, completion clear and scan clear, and one scan read port.
module cpl_tag_table
    import pcie_txn_pkg::*;
#(
    parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
    parameter int TAG_COUNT   = DEF_TAG_COUNT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         allocEn_i,
    input  logic [$clog2(TAG_COUNT)-1:0] allocTag_i,
    input  logic [TIMER_WIDTH-1:0]       allocStamp_i,
    input  logic                         cplClrEn_i,
    input  logic [$clog2(TAG_COUNT)-1:0] cplClrTag_i,
    input  logic                         scanClrEn_i,
    input  logic [$clog2(TAG_COUNT)-1:0] scanTag_i,
    output logic [TAG_COUNT-1:0]         valid_o,
    output logic [TIMER_WIDTH-1:0]       scanStamp_o
);

    logic [TAG_COUNT-1:0]   valid_q;
    logic [TAG_COUNT-1:0]   valid_d;
    logic [TIMER_WIDTH-1:0] stamp_q [TAG_COUNT];

    // Allocation is applied last so a same-cycle completion+request leaves the tag valid.
    always_comb begin
        valid_d = valid_q;
        if (cplClrEn_i) begin
            valid_d[cplClrTag_i] = 1'b0;
        end
        if (scanClrEn_i) begin
            valid_d[scanTag_i] = 1'b0;
        end
        if (allocEn_i) begin
            valid_d[allocTag_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Stamps carry no reset; they are only looked at while the tag is valid.
    always_ff @(posedge clk) begin
        if (allocEn_i) begin
            stamp_q[allocTag_i] <= allocStamp_i;
        end
    end

    assign valid_o     = valid_q;
    assign scanStamp_o = stamp_q[scanTag_i];

endmodule

// File: rtl/cpl_timeout_tracker.sv
// Tracks outstanding non-posted tags, flags protocol errors and reports
// tags whose completion has not arrived within TIMEOUT timer ticks.
module cpl_timeout_tracker
    import pcie_txn_pkg::*;
#(
    parameter int                     TIMER_WIDTH = DEF_TIMER_WIDTH,
    parameter int                     TAG_COUNT   = DEF_TAG_COUNT,
    parameter logic [TIMER_WIDTH-1:0] TIMEOUT     = TIMER_WIDTH'(1000)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TIMER_WIDTH-1:0]       timer,
    input  logic                         req_valid,
    input  logic [$clog2(TAG_COUNT)-1:0] req_tag,
    input  logic                         cpl_valid,
    input  logic [$clog2(TAG_COUNT)-1:0] cpl_tag,
    input  logic                         cpl_last,
    output logic                         timeout_valid,
    output logic [$clog2(TAG_COUNT)-1:0] timeout_tag,
    input  logic                         timeout_ready,
    output logic [$clog2(TAG_COUNT):0]   outstanding,
    output logic                         err_tag_reuse,
    output logic                         err_unexp_cpl
);

    localparam int TAG_W = $clog2(TAG_COUNT);
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_COUNT-1:0]   tagValid;
    logic [TIMER_WIDTH-1:0] scanStamp;
    logic [TIMER_WIDTH-1:0] elapsed;
    logic                   cplClear, reqRefresh, alloc, stall, scanBusy, expire;

    to_state_e              toState_q, toState_d;
    logic [TAG_W-1:0]       timeoutTag_q, timeoutTag_d;
    logic [TAG_W-1:0]       scanPtr_q, scanPtr_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic                   errReuse_q, errReuse_d;
    logic                   errUnexp_q, errUnexp_d;

    cpl_tag_table #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .TAG_COUNT   (TAG_COUNT)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .allocEn_i    (alloc),
        .allocTag_i   (req_tag),
        .allocStamp_i (timer),
        .cplClrEn_i   (cplClear),
        .cplClrTag_i  (cpl_tag),
        .scanClrEn_i  (expire),
        .scanTag_i    (scanPtr_q),
        .valid_o      (tagValid),
        .scanStamp_o  (scanStamp)
    );

    // A last completion to the same tag frees it just in time for the new request.
    always_comb begin
        cplClear   = cpl_valid && cpl_last && tagValid[cpl_tag];
        reqRefresh = cplClear && (req_tag == cpl_tag);
        alloc      = req_valid && (!tagValid[req_tag] || reqRefresh);
        errReuse_d = req_valid && tagValid[req_tag] && !reqRefresh;
        errUnexp_d = cpl_valid && !tagValid[cpl_tag];
    end

    // A pending unaccepted report freezes the scan; tags touched this cycle are not judged.
    always_comb begin
        stall    = (toState_q == TO_PENDING) && !timeout_ready;
        scanBusy = (req_valid && (req_tag == scanPtr_q)) ||
                   (cpl_valid && (cpl_tag == scanPtr_q));
        elapsed  = timer - scanStamp;
        expire   = !stall && !scanBusy && tagValid[scanPtr_q] && (elapsed >= TIMEOUT);
    end

    always_comb begin
        toState_d     = toState_q;
        timeoutTag_d  = timeoutTag_q;
        scanPtr_d     = scanPtr_q;
        outstanding_d = outstanding_q + CNT_W'(alloc) - CNT_W'(cplClear) - CNT_W'(expire);
        if ((toState_q == TO_PENDING) && timeout_ready) begin
            toState_d = TO_IDLE;
        end
        if (expire) begin
            toState_d    = TO_PENDING;
            timeoutTag_d = scanPtr_q;
        end
        if (!stall) begin
            scanPtr_d = scanPtr_q + TAG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toState_q     <= TO_IDLE;
            timeoutTag_q  <= '0;
            scanPtr_q     <= '0;
            outstanding_q <= '0;
            errReuse_q    <= 1'b0;
            errUnexp_q    <= 1'b0;
        end else begin
            toState_q     <= toState_d;
            timeoutTag_q  <= timeoutTag_d;
            scanPtr_q     <= scanPtr_d;
            outstanding_q <= outstanding_d;
            errReuse_q    <= errReuse_d;
            errUnexp_q    <= errUnexp_d;
        end
    end

    assign timeout_valid = (toState_q == TO_PENDING);
    assign timeout_tag   = timeoutTag_q;
    assign outstanding   = outstanding_q;
    assign err_tag_reuse = errReuse_q;
    assign err_unexp_cpl = errUnexp_q;

endmodule

// File: tb/tb_cpl_timeout_tracker.sv
// Self-checking bench for cpl_timeout_tracker: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a tag model.
module tb_cpl_timeout_tracker;
    import pcie_txn_pkg::*;

    localparam int             TW        = 44;
    localparam int             TC        = 32;
    localparam logic [TW-1:0]  TIMEOUT_V = 44'd10;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] timer;
    logic          req_valid;
    tag_t          req_tag;
    logic          cpl_valid;
    tag_t          cpl_tag;
    logic          cpl_last;
    logic          timeout_valid;
    tag_t          timeout_tag;
    logic          timeout_ready;
    logic [5:0]    outstanding;
    logic          err_tag_reuse;
    logic          err_unexp_cpl;

    int            nChecks = 0;
    int            nPass   = 0;
    logic [TW-1:0] timerStep;

    // Reference state: which tags are live, when they were issued, and the expected outputs.
    bit [TC-1:0]   mValid;
    logic [TW-1:0] mStamp [TC];
    int            mPtr;
    bit            mTv;
    int            mTag;
    int            mOut;
    bit            mErrR;
    bit            mErrC;

    cpl_timeout_tracker #(
        .TIMER_WIDTH (TW),
        .TAG_COUNT   (TC),
        .TIMEOUT     (TIMEOUT_V)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .timer         (timer),
        .req_valid     (req_valid),
        .req_tag       (req_tag),
        .cpl_valid     (cpl_valid),
        .cpl_tag       (cpl_tag),
        .cpl_last      (cpl_last),
        .timeout_valid (timeout_valid),
        .timeout_tag   (timeout_tag),
        .timeout_ready (timeout_ready),
        .outstanding   (outstanding),
        .err_tag_reuse (err_tag_reuse),
        .err_unexp_cpl (err_unexp_cpl)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs from a negedge, returns at the following negedge.
    task automatic applyStimulus(input bit rv, input int rt, input bit cv, input int ct,
                                 input bit cl, input bit tr);
        req_valid     = rv;
        req_tag       = tag_t'(rt);
        cpl_valid     = cv;
        cpl_tag       = tag_t'(ct);
        cpl_last      = cl;
        timeout_ready = tr;
        @(negedge clk);
        timer = timer + timerStep;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b1, 4, 1'b1, 4, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    task automatic waitForTimeout(input int bound, input bit tr, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (timeout_valid) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, tr);
        end
        if (timeout_valid) found = 1'b1;
    endtask

    task automatic watchQuiet(input int n, output bit saw);
        saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
            saw = saw | timeout_valid;
        end
    endtask

    // Each cycle: completion first, then the request, with the scan judging one untouched tag.
    always @(posedge clk) begin : refModel
        bit            stall, busy, expNow, cplHit;
        int            s, rq, cq;
        logic [TW-1:0] el;
        if (rst) begin
            mValid = '0;
            mPtr   = 0;
            mTv    = 1'b0;
            mTag   = 0;
            mErrR  = 1'b0;
            mErrC  = 1'b0;
        end else begin
            rq     = int'(req_tag);
            cq     = int'(cpl_tag);
            stall  = mTv && !timeout_ready;
            expNow = 1'b0;
            s      = mPtr;
            if (!stall) begin
                busy   = (req_valid && rq == s) || (cpl_valid && cq == s);
                el     = timer - mStamp[s];
                expNow = !busy && mValid[s] && (el >= TIMEOUT_V);
                mPtr   = (mPtr + 1) % TC;
            end
            cplHit = mValid[cq];
            mErrC  = cpl_valid && !cplHit;
            if (mTv && timeout_ready) mTv = 1'b0;
            if (expNow) begin
                mTv       = 1'b1;
                mTag      = s;
                mValid[s] = 1'b0;
            end
            if (cpl_valid && cpl_last && cplHit) mValid[cq] = 1'b0;
            mErrR = 1'b0;
            if (req_valid) begin
                if (mValid[rq]) begin
                    mErrR = 1'b1;
                end else begin
                    mValid[rq] = 1'b1;
                    mStamp[rq] = timer;
                end
            end
        end
        mOut = $countones(mValid);
    end

    // Compare every output against the model shortly after each active edge.
    always @(posedge clk) begin
        #1;
        checkOutput("timeout_valid", 64'(timeout_valid), 64'(mTv));
        if (mTv) checkOutput("timeout_tag", 64'(timeout_tag), 64'(mTag));
        checkOutput("outstanding", 64'(outstanding), 64'(mOut));
        checkOutput("err_tag_reuse", 64'(err_tag_reuse), 64'(mErrR));
        checkOutput("err_unexp_cpl", 64'(err_unexp_cpl), 64'(mErrC));
    end

    initial begin
        bit            found, saw, heldOk;
        int            lastTag;
        logic [TW-1:0] el;
        rst = 1'b1;
        timer = '0;
        timerStep = 44'd1;
        req_valid = 1'b0; req_tag = '0;
        cpl_valid = 1'b0; cpl_tag = '0; cpl_last = 1'b0;
        timeout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_timeout_valid", 64'(timeout_valid), 64'd0);
        checkOutput("reset_outstanding", 64'(outstanding), 64'd0);
        checkOutput("reset_errors", 64'({err_tag_reuse, err_unexp_cpl}), 64'd0);

        $display("[TB] basic expiry");
        timer = 44'd100;
        applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("basic_outstanding_1", 64'(outstanding), 64'd1);
        waitForTimeout(60, 1'b1, found);
        checkOutput("basic_found", 64'(found), 64'd1);
        checkOutput("basic_tag", 64'(timeout_tag), 64'd3);
        checkOutput("basic_outstanding_0", 64'(outstanding), 64'd0);
        el = timer - 44'd1 - 44'd100;
        checkOutput("basic_elapsed_reached", 64'(el >= 44'd10), 64'd1);
        applyStimulus(1'b0, 0, 1'b1, 3, 1'b1, 1'b1);
        checkOutput("basic_single_report", 64'(timeout_valid), 64'd0);
        checkOutput("late_cpl_unexpected", 64'(err_unexp_cpl), 64'd1);

        $display("[TB] normal completion");
        applyStimulus(1'b1, 5, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 5, 1'b1, 1'b1);
        checkOutput("normal_outstanding", 64'(outstanding), 64'd0);
        checkOutput("normal_errors", 64'({err_tag_reuse, err_unexp_cpl}), 64'd0);
        watchQuiet(40, saw);
        checkOutput("normal_no_timeout", 64'(saw), 64'd0);

        $display("[TB] timer wrap");
        doReset();
        timerStep = '0;
        timer = 44'hFFF_FFFF_FFFD;
        applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 1'b1);
        timer = 44'hFFF_FFFF_FFFF;
        applyStimulus(1'b1, 4, 1'b0, 0, 1'b0, 1'b1);
        timer = 44'd2;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("wrap_quiet_before", 64'(timeout_valid), 64'd0);
        timer = 44'd7;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("wrap_expire_valid", 64'(timeout_valid), 64'd1);
        checkOutput("wrap_expire_tag", 64'(timeout_tag), 64'd3);
        timer = 44'd8;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("wrap_elapsed9_quiet", 64'(timeout_valid), 64'd0);
        checkOutput("wrap_outstanding", 64'(outstanding), 64'd1);
        timerStep = 44'd1;
        watchQuiet(40, saw);

        $display("[TB] backpressure");
        doReset();
        timer = 44'd1000;
        for (int t = 0; t < 3; t++) applyStimulus(1'b1, t, 1'b0, 0, 1'b0, 1'b0);
        waitForTimeout(80, 1'b0, found);
        checkOutput("bp_found", 64'(found), 64'd1);
        checkOutput("bp_first_tag", 64'(timeout_tag), 64'd0);
        checkOutput("bp_outstanding", 64'(outstanding), 64'd2);
        heldOk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
            heldOk = heldOk && timeout_valid && (timeout_tag == tag_t'(0));
        end
        checkOutput("bp_held_stable", 64'(heldOk), 64'd1);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("bp_second_tag", 64'({timeout_valid, timeout_tag}), 64'({1'b1, tag_t'(1)}));
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("bp_third_tag", 64'({timeout_valid, timeout_tag}), 64'({1'b1, tag_t'(2)}));
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("bp_drained", 64'(timeout_valid), 64'd0);
        checkOutput("bp_outstanding_0", 64'(outstanding), 64'd0);

        $display("[TB] error cases");
        doReset();
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("reuse_pulse", 64'(err_tag_reuse), 64'd1);
        checkOutput("reuse_outstanding", 64'(outstanding), 64'd1);
        applyStimulus(1'b0, 0, 1'b1, 9, 1'b1, 1'b1);
        checkOutput("reuse_one_cycle", 64'(err_tag_reuse), 64'd0);
        checkOutput("unexp_pulse", 64'(err_unexp_cpl), 64'd1);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("unexp_one_cycle", 64'(err_unexp_cpl), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 7, 1'b1, 7, 1'b1, 1'b1);
        checkOutput("refresh_no_error", 64'({err_tag_reuse, err_unexp_cpl}), 64'd0);
        checkOutput("refresh_outstanding", 64'(outstanding), 64'd1);
        // Old stamp would now be 13 ticks old, the refreshed one only 5.
        timer = timer + 44'd4;
        timerStep = '0;
        watchQuiet(40, saw);
        checkOutput("refresh_no_timeout", 64'(saw), 64'd0);
        checkOutput("refresh_still_live", 64'(outstanding), 64'd1);
        timerStep = 44'd1;

        $display("[TB] reset mid-operation");
        doReset();
        for (int t = 10; t < 15; t++) applyStimulus(1'b1, t, 1'b0, 0, 1'b0, 1'b0);
        waitForTimeout(80, 1'b0, found);
        checkOutput("midrst_pending", 64'(found), 64'd1);
        checkOutput("midrst_outstanding_4", 64'(outstanding), 64'd4);
        doReset();
        checkOutput("midrst_timeout_valid", 64'(timeout_valid), 64'd0);
        checkOutput("midrst_timeout_tag", 64'(timeout_tag), 64'd0);
        checkOutput("midrst_outstanding", 64'(outstanding), 64'd0);
        checkOutput("midrst_errors", 64'({err_tag_reuse, err_unexp_cpl}), 64'd0);
        watchQuiet(60, saw);
        checkOutput("midrst_no_timeout", 64'(saw), 64'd0);

        $display("[TB] randomized traffic");
        timer = 44'hFFF_FFFF_FE00;
        lastTag = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rv, cv, cl, tr;
            int rt, ct;
            rv = ($urandom_range(0, 9) < 3);
            rt = $urandom_range(0, TC - 1);
            cv = ($urandom_range(0, 9) < 3);
            ct = ($urandom_range(0, 1) == 0) ? lastTag : $urandom_range(0, TC - 1);
            cl = ($urandom_range(0, 3) != 0);
            tr = ($urandom_range(0, 3) != 0);
            timerStep = 44'($urandom_range(0, 2));
            if (rv) lastTag = rt;
            rst = ($urandom_range(0, 399) == 0);
            applyStimulus(rv, rt, cv, ct, cl, tr);
        end
        rst = 1'b0;
        timerStep = 44'd1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/cpl_timeout_tracker.md
CPL_TIMEOUT_TRACKER -- requirements
Module: cpl_timeout_tracker

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 44: width of the timestamp input.
REQ-002 SHALL have parameter TAG_COUNT, default 32: number of trackable non-posted request tags, a power of 2.
REQ-003 SHALL have parameter TIMEOUT, default 1000: elapsed timer ticks at which an outstanding tag expires, 1 to 2^(TIMER_WIDTH-1).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port timer  in  TIMER_WIDTH  free-running timestamp from the timer stage.
REQ-006 SHALL have ports req_valid  in  1  and req_tag  in  log2(TAG_COUNT), for a non-posted request issued with that tag.
REQ-007 SHALL have ports cpl_valid  in  1, cpl_tag  in  log2(TAG_COUNT), and cpl_last  in  1  (final completion for the tag).
REQ-008 SHALL have ports timeout_valid  out  1, timeout_tag  out  log2(TAG_COUNT), and timeout_ready  in  1.
REQ-009 SHALL have port outstanding  out  log2(TAG_COUNT)+1  count of valid tag entries.
REQ-010 SHALL have ports err_tag_reuse  out  1  and err_unexp_cpl  out  1, each a one-cycle pulse.

Function
REQ-011 SHALL hold, per tag, a valid bit and a TIMER_WIDTH issue stamp.
REQ-012 SHALL set the valid bit and capture timer as the stamp on req_valid to an invalid tag, effective the next cycle.
REQ-013 SHALL pulse err_tag_reuse on req_valid to a valid tag (unless REQ-016 applies) and leave that entry unchanged.
REQ-014 SHALL clear the valid bit on cpl_valid && cpl_last to a valid tag, and leave the entry unchanged for cpl_valid with cpl_last=0.
REQ-015 SHALL pulse err_unexp_cpl on cpl_valid to an invalid tag, regardless of cpl_last.
REQ-016 SHALL, when req and a last completion target the same valid tag in the same cycle, apply the completion first and then the request: entry valid with the new stamp, no error.
REQ-017 SHALL visit one tag per cycle with a scan pointer, incrementing modulo TAG_COUNT and wrapping from TAG_COUNT-1 to 0.
REQ-018 SHALL compute elapsed as (timer - stamp) modulo 2^TIMER_WIDTH; the tag SHALL be expired when valid and elapsed >= TIMEOUT.
REQ-019 SHALL, for an expired scanned tag, clear its entry and register timeout_valid=1 with timeout_tag = that tag on the next cycle.
REQ-020 SHALL hold timeout_valid and timeout_tag stable until timeout_valid && timeout_ready, and stall the scan pointer while timeout_valid=1 && timeout_ready=0.
REQ-021 SHALL support back-to-back timeouts on consecutive cycles when timeout_ready is held at 1.
REQ-022 SHALL skip expiry evaluation for a scanned tag that is targeted by req_valid or cpl_valid in the same cycle; the pointer SHALL still advance.
REQ-023 SHALL treat a completion arriving after its tag timed out as unexpected (REQ-015).
REQ-024 SHALL update outstanding each cycle as +1 per allocation and -1 per clear (completion or timeout), netting to 0 in the REQ-016 case.
REQ-025 SHALL keep outstanding within 0..TAG_COUNT.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, clear all valid bits and set the scan pointer, timeout_valid, timeout_tag, outstanding, err_tag_reuse and err_unexp_cpl to 0.
REQ-027 SHALL ignore req, cpl and timeout_ready while rst=1, and discard a pending timeout without a handshake.
REQ-028 SHALL leave stamps undefined after reset; they are never read while the entry is invalid.

Structure
REQ-029 SHALL take TIMER_WIDTH and TAG_COUNT defaults and a tag typedef from a shared package, pcie_txn_pkg.
REQ-030 SHALL implement the valid/stamp storage as one sub-module, cpl_tag_table, with one write port per source and one scan read port.

Verification
REQ-031 SHALL cover basic expiry: TIMEOUT=10, req tag 3 at timer=100, no completion -> timeout_tag=3 once elapsed >= 10 and within TAG_COUNT further cycles; outstanding 1 -> 0.
REQ-032 SHALL cover a normal completion: req tag 5, cpl tag 5 with cpl_last=1 after 4 cycles -> no timeout, outstanding 0, no error pulses.
REQ-033 SHALL cover timer wrap: stamp = 2^44 - 3, timer wraps to 7, TIMEOUT=10 -> expiry flagged, elapsed = 10.
REQ-034 SHALL cover backpressure: tags 0, 1 and 2 expired, timeout_ready=0 for 20 cycles -> tag 0 held stable, then 0, 1, 2 on consecutive cycles once ready=1.
REQ-035 SHALL cover error cases: req tag 7 twice -> err_tag_reuse 1 cycle; cpl tag 9 when never issued -> err_unexp_cpl; same-cycle req+cpl_last on valid tag 7 -> no error, stamp refreshed.
REQ-036 SHALL cover reset mid-operation: rst with 4 tags outstanding and timeout pending -> all outputs 0 next cycle, no later timeouts.
